rr_grant_ctrl: RTL
==================

// Module: rr_grant_ctrl
// PURPOSE
//  Round-robin arbiter/scheduler for a 4-way shared resource.
//  Up to 4 requesters compete for the resource. The block produces a registered one-hot grant plus an
//  index/enable pair (gnt_idx, gnt_vld) that drives a 2:4 decoder's a/en inputs directly.
//  Grants are held until the requester releases or a hold limit expires.
// PARAMETERS
//  MAX_HOLD  8  max consecutive cycles one grant may last; legal 1..255 (8-bit counter)
// PORTS
//  clk        in   1  clock; all state updates on rising edge
//  rst_n      in   1  reset, synchronous, active-low
//  req        in   4  request per requester; level, held high while resource wanted
//  gnt        out  4  one-hot grant, registered; 4'b0000 when no grant
//  gnt_idx    out  2  index of current grantee (decoder a); holds last value when gnt_vld=0
//  gnt_vld    out  1  grant active (decoder en)
//  timeout    out  1  1-cycle pulse: grant was forcibly ended by MAX_HOLD
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, ptr=0, hold_cnt=0.
//   Reset applied mid-grant clears the grant at that same edge. There is no partial release and no timeout pulse.
//  Internal state: ptr[1:0] = next requester with top priority; hold_cnt[7:0] counts granted cycles.
//  FSM states: IDLE, GRANT.
//  IDLE:
//   - Scan req starting at ptr, ascending with wrap 3->0. The first set bit wins.
//   - If any req is set: at this edge gnt_idx<=winner, gnt_vld<=1, gnt<=1<<winner, hold_cnt<=1 -> GRANT.
//   - If req==0: stay in IDLE. Outputs unchanged (gnt_vld=0).
//   - Latency: req sampled at edge k -> gnt visible in the cycle after edge k.
//  GRANT:
//   - Release case, req[gnt_idx]==0 at the edge:
//     gnt<=0, gnt_vld<=0, ptr<=gnt_idx+1 (mod 4) -> IDLE.
//   - Timeout case, req[gnt_idx]==1 and hold_cnt==MAX_HOLD:
//     gnt<=0, gnt_vld<=0, timeout<=1, ptr<=gnt_idx+1 -> IDLE.
//   - Otherwise: hold_cnt<=hold_cnt+1; grant unchanged.
//   - Release and timeout in the same cycle: release wins, and timeout stays 0.
//   - Changes on the other req lines are ignored while in GRANT.
//  Invariants:
//   - A grant lasts at most MAX_HOLD cycles.
//   - There is always >=1 cycle with gnt_vld=0 between two grants, so decoder outputs never overlap.
//  timeout is high only in the single cycle after the last granted cycle; otherwise 0.
//  gnt == (gnt_vld ? 4'b1 << gnt_idx : 4'b0) at all times; popcount(gnt) <= 1.
//  Fairness: a requester that keeps req high is granted within 3*(MAX_HOLD+1) cycles.
//  hold_cnt never exceeds MAX_HOLD, so there is no wrap. MAX_HOLD=0 is illegal; the bench flags it.
// TESTING
//  1. Reset: rst_n=0 for 2 edges with req=4'b1111 -> gnt=0, gnt_vld=0, gnt_idx=0, timeout=0.
//  2. Single: req=4'b0100 from edge 0 -> edge 1: gnt=4'b0100, gnt_idx=2, gnt_vld=1.
//     Grant held for 8 cycles, then gnt=0 and timeout=1 for 1 cycle. After the 1 dead cycle, requester 2 is re-granted.
//  3. Round-robin: req=4'b1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0.
//     Each grant lasts 8 cycles with a timeout pulse after it and 1 idle cycle between grants.
//  4. Early release: requester 1 granted, req[1] dropped after 3 granted cycles, req[3]=1 pending ->
//     gnt=0 next cycle, timeout=0, then gnt=4'b1000. ptr was 2, so 3 is chosen over a pending 0.
//  5. Boundary: req[0] drops at the edge where hold_cnt==MAX_HOLD -> grant ends, timeout stays 0.
//  6. Reset mid-grant: rst_n=0 during cycle 4 of a grant to requester 2 -> next cycle gnt=0, timeout=0, ptr=0.
//     With req=4'b1111 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter for a 4-way shared resource with a bounded hold time.
// Emits a registered one-hot grant plus an index/enable pair that drives a 2:4 decoder.
module rr_grant_ctrl #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_idx,
    output logic       o_gnt_vld,
    output logic       o_timeout
);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e     r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_idx;
    logic       r_gnt_vld;
    logic       r_timeout;

    logic       w_any;
    logic       w_found;
    logic [1:0] w_cand;
    logic [1:0] w_winner;
    logic       w_own_req;
    logic       w_hold_max;

    // First requester found scanning upward from r_ptr, wrapping 3 -> 0.
    always_comb begin
        w_any    = |i_req;
        w_found  = 1'b0;
        w_cand   = r_ptr;
        w_winner = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_cand = r_ptr + 2'(i);
            if (!w_found && i_req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign w_own_req  = i_req[r_gnt_idx];
    assign w_hold_max = (r_hold_cnt == 8'(MAX_HOLD));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_ptr      <= 2'd0;
            r_hold_cnt <= 8'd0;
            r_gnt      <= 4'b0000;
            r_gnt_idx  <= 2'd0;
            r_gnt_vld  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_gnt_idx  <= w_winner;
                        r_gnt_vld  <= 1'b1;
                        r_gnt      <= 4'b0001 << w_winner;
                        r_hold_cnt <= 8'd1;
                        r_state    <= StGrant;
                    end
                end
                StGrant: begin
                    // A release on the limit cycle is a normal release, not a timeout.
                    if (!w_own_req) begin
                        r_gnt     <= 4'b0000;
                        r_gnt_vld <= 1'b0;
                        r_ptr     <= r_gnt_idx + 2'd1;
                        r_state   <= StIdle;
                    end else if (w_hold_max) begin
                        r_gnt     <= 4'b0000;
                        r_gnt_vld <= 1'b0;
                        r_timeout <= 1'b1;
                        r_ptr     <= r_gnt_idx + 2'd1;
                        r_state   <= StIdle;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_idx = r_gnt_idx;
    assign o_gnt_vld = r_gnt_vld;
    assign o_timeout = r_timeout;

    a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_gnt));
    a_hold_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_hold_cnt <= 8'(MAX_HOLD));
    a_timeout_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_timeout |-> !r_gnt_vld);

endmodule
